// File: rtl/demux_pkg.sv
// Shared constants and lane-select decode for the registered 1-to-4 demux.
package demux_pkg;

    localparam int LANES = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] lane_idx_t;

    localparam lane_idx_t LANE1 = 2'd0;
    localparam lane_idx_t LANE2 = 2'd1;
    localparam lane_idx_t LANE3 = 2'd2;
    localparam lane_idx_t LANE4 = 2'd3;

    // Anything that is not an explicit lane code, including X, lands on lane4.
    function automatic lane_idx_t decode_sel(input logic [SEL_W-1:0] sel);
        case (sel)
            LANE1:   return LANE1;
            LANE2:   return LANE2;
            LANE3:   return LANE3;
            default: return LANE4;
        endcase
    endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// One-entry holding register for a single demux output lane.
module demux_lane_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ready_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    // A load on the same edge as a drain keeps the lane full with the new word.
    always_comb begin
        valid_d = load | (valid_q & ~ready_in);
        data_d  = load ? data_in : data_q;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;

endmodule

// File: rtl/demux_one_to_four.sv
// Registered 1-to-4 demultiplexer with per-lane valid/ready holding registers.
// Define DEMUX_ROUND_ROBIN_EN to steer by an internal rotating pointer instead of iSel.
module demux_one_to_four
    import demux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic [WIDTH-1:0] iData,
    input  logic [SEL_W-1:0] iSel,
    input  logic             iValid,
    output logic             oReady,
    output logic [WIDTH-1:0] oData1,
    output logic [WIDTH-1:0] oData2,
    output logic [WIDTH-1:0] oData3,
    output logic [WIDTH-1:0] oData4,
    output logic [LANES-1:0] oValid,
    input  logic [LANES-1:0] iReady
);

    lane_idx_t        sel_idx;
    logic             accept;
    logic [LANES-1:0] lane_load;
    logic [LANES-1:0] lane_valid;
    logic [WIDTH-1:0] lane_data [LANES];

`ifdef DEMUX_ROUND_ROBIN_EN
    lane_idx_t ptr_q, ptr_d;
    logic      unused_sel;

    assign unused_sel = ^iSel;

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = ptr_q + 2'd1;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            ptr_q <= LANE1;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign sel_idx = ptr_q;
`else
    assign sel_idx = decode_sel(iSel);
`endif

    // Combinational iSel/iReady -> oReady path; independent of iValid.
    assign oReady = ~lane_valid[sel_idx] | iReady[sel_idx];
    assign accept = iValid & oReady;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_load[gi] = accept & (sel_idx == lane_idx_t'(gi));

            demux_lane_reg #(
                .WIDTH (WIDTH)
            ) u_lane (
                .iClk      (iClk),
                .iRst      (iRst),
                .load      (lane_load[gi]),
                .data_in   (iData),
                .ready_in  (iReady[gi]),
                .valid_out (lane_valid[gi]),
                .data_out  (lane_data[gi])
            );
        end
    endgenerate

    assign oValid = lane_valid;
    assign oData1 = lane_data[0];
    assign oData2 = lane_data[1];
    assign oData3 = lane_data[2];
    assign oData4 = lane_data[3];

endmodule
